// File: rtl/enemy_pkg.sv
// Shared types and default geometry for the enemy formation controller.
package enemy_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MARCH   = 3'd1,
        DROP    = 3'd2,
        CLEARED = 3'd3,
        LANDED  = 3'd4
    } state_t;

    localparam int unsigned POS_W               = 10;
    localparam int unsigned DEF_N_ENEMIES       = 8;
    localparam int unsigned DEF_COL_PITCH       = 60;
    localparam int unsigned DEF_ENEMY_W         = 50;
    localparam int unsigned DEF_ENEMY_H         = 50;
    localparam int unsigned DEF_START_X         = 20;
    localparam int unsigned DEF_START_Y         = 40;
    localparam int unsigned DEF_SCREEN_W        = 640;
    localparam int unsigned DEF_BOTTOM_Y        = 400;
    localparam int unsigned DEF_STEP_X          = 4;
    localparam int unsigned DEF_DROP_Y          = 10;
    localparam int unsigned DEF_FRAMES_PER_STEP = 30;
    localparam int unsigned DEF_MIN_FRAMES      = 6;
    localparam int unsigned DEF_SPEEDUP_DEC     = 3;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vsync level into the Clk domain and emits a one-Clk pulse per rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_tick
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic tick_r;

    // Two-flop synchroniser followed by a registered rising-edge detector.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            meta_r <= frame_clk;
            sync_r <= meta_r;
            prev_r <= sync_r;
            tick_r <= sync_r & ~prev_r;
        end
    end

    assign frame_tick = tick_r;

endmodule

// File: rtl/enemy_formation_ctrl.sv
// Space-invader style formation: marches sideways on frame steps, drops at the edges.
// Optional ENEMY_SPEEDUP_EN shortens the step period as enemies die.
module enemy_formation_ctrl
    import enemy_pkg::*;
#(
    parameter int unsigned N_ENEMIES       = DEF_N_ENEMIES,
    parameter int unsigned COL_PITCH       = DEF_COL_PITCH,
    parameter int unsigned ENEMY_W         = DEF_ENEMY_W,
    parameter int unsigned ENEMY_H         = DEF_ENEMY_H,
    parameter int unsigned START_X         = DEF_START_X,
    parameter int unsigned START_Y         = DEF_START_Y,
    parameter int unsigned SCREEN_W        = DEF_SCREEN_W,
    parameter int unsigned BOTTOM_Y        = DEF_BOTTOM_Y,
    parameter int unsigned STEP_X          = DEF_STEP_X,
    parameter int unsigned DROP_Y          = DEF_DROP_Y,
    parameter int unsigned FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
    parameter int unsigned MIN_FRAMES      = DEF_MIN_FRAMES,
    parameter int unsigned SPEEDUP_DEC     = DEF_SPEEDUP_DEC
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_clk,
    input  logic                 start,
    input  logic [N_ENEMIES-1:0] enemy_hit,
    output logic                 enemy_direction_X,
    output logic                 enemy_direction_Y,
    output logic [POS_W-1:0]     formation_x,
    output logic [POS_W-1:0]     formation_y,
    output logic [N_ENEMIES-1:0] alive,
    output logic                 delete_enemies,
    output logic                 cleared,
    output logic                 landed
);

    localparam logic [N_ENEMIES-1:0] ALL_ALIVE = {N_ENEMIES{1'b1}};
    localparam logic [N_ENEMIES-1:0] NONE_ALIVE = {N_ENEMIES{1'b0}};

    state_t               state_r, state_s;
    logic [POS_W-1:0]     x_r, x_s, y_r, y_s;
    logic                 dirx_r, dirx_s, diry_r, diry_s;
    logic [N_ENEMIES-1:0] alive_r, alive_s;
    logic [POS_W-1:0]     cnt_r, cnt_s;
    logic                 del_r, del_s, clr_r, clr_s, lnd_r, lnd_s;
    logic                 frame_tick_s;
    logic [POS_W-1:0]     period_s;
    logic [POS_W-1:0]     lo_s, hi_s, left_s, right_s, drop_y_s;

    frame_tick_sync u_sync (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick_s)
    );

`ifdef ENEMY_SPEEDUP_EN
    logic [POS_W-1:0] dead_s, dec_s;

    function automatic logic [POS_W-1:0] popcount(input logic [N_ENEMIES-1:0] v);
        logic [POS_W-1:0] n;
        n = 10'd0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            n = n + {9'd0, v[i]};
        end
        return n;
    endfunction

    // Step period shrinks with each dead enemy, clamped at the floor.
    always_comb begin
        dead_s = popcount(~alive_r);
        dec_s  = dead_s * 10'(SPEEDUP_DEC);
        if (dec_s + 10'(MIN_FRAMES) < 10'(FRAMES_PER_STEP)) begin
            period_s = 10'(FRAMES_PER_STEP) - dec_s;
        end else begin
            period_s = 10'(MIN_FRAMES);
        end
    end
`else
    assign period_s = 10'(FRAMES_PER_STEP);
`endif

    // Outermost live columns set the formation's effective edges.
    always_comb begin
        lo_s = 10'd0;
        hi_s = 10'd0;
        for (int i = N_ENEMIES - 1; i >= 0; i--) begin
            lo_s = alive_r[i] ? 10'(i) : lo_s;
        end
        for (int i = 0; i < N_ENEMIES; i++) begin
            hi_s = alive_r[i] ? 10'(i) : hi_s;
        end
        left_s   = x_r + lo_s * 10'(COL_PITCH);
        right_s  = x_r + hi_s * 10'(COL_PITCH) + 10'(ENEMY_W);
        drop_y_s = y_r + 10'(DROP_Y);
    end

    // Next-state and next-value logic; edge checks use the pre-hit mask.
    always_comb begin
        state_s = state_r;
        x_s     = x_r;
        y_s     = y_r;
        dirx_s  = dirx_r;
        diry_s  = 1'b0;
        alive_s = alive_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                x_s     = 10'(START_X);
                y_s     = 10'(START_Y);
                alive_s = ALL_ALIVE;
                dirx_s  = 1'b1;
                cnt_s   = 10'd0;
                if (start) begin
                    state_s = MARCH;
                end else begin
                    state_s = IDLE;
                end
            end
            MARCH: begin
                alive_s = alive_r & ~enemy_hit;
                if (alive_s == NONE_ALIVE) begin
                    state_s = CLEARED;
                end else if (frame_tick_s) begin
                    if (cnt_r >= period_s - 10'd1) begin
                        cnt_s = 10'd0;
                        if (dirx_r) begin
                            if (right_s + 10'(STEP_X) <= 10'(SCREEN_W)) begin
                                x_s = x_r + 10'(STEP_X);
                            end else begin
                                state_s = DROP;
                            end
                        end else begin
                            if (left_s >= 10'(STEP_X)) begin
                                x_s = x_r - 10'(STEP_X);
                            end else begin
                                state_s = DROP;
                            end
                        end
                    end else begin
                        cnt_s = cnt_r + 10'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            DROP: begin
                alive_s = alive_r & ~enemy_hit;
                if (alive_s == NONE_ALIVE) begin
                    state_s = CLEARED;
                end else begin
                    y_s    = drop_y_s;
                    dirx_s = ~dirx_r;
                    diry_s = 1'b1;
                    if (drop_y_s + 10'(ENEMY_H) >= 10'(BOTTOM_Y)) begin
                        state_s = LANDED;
                    end else begin
                        state_s = MARCH;
                    end
                end
            end
            CLEARED, LANDED: begin
                if (start) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        clr_s = (state_s == CLEARED);
        lnd_s = (state_s == LANDED);
        del_s = (state_s == IDLE) || (state_s == CLEARED) || (state_s == LANDED);
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
            x_r     <= 10'(START_X);
            y_r     <= 10'(START_Y);
            dirx_r  <= 1'b1;
            diry_r  <= 1'b0;
            alive_r <= ALL_ALIVE;
            cnt_r   <= 10'd0;
            del_r   <= 1'b1;
            clr_r   <= 1'b0;
            lnd_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            x_r     <= x_s;
            y_r     <= y_s;
            dirx_r  <= dirx_s;
            diry_r  <= diry_s;
            alive_r <= alive_s;
            cnt_r   <= cnt_s;
            del_r   <= del_s;
            clr_r   <= clr_s;
            lnd_r   <= lnd_s;
        end
    end

    assign formation_x       = x_r;
    assign formation_y       = y_r;
    assign enemy_direction_X = dirx_r;
    assign enemy_direction_Y = diry_r;
    assign alive             = alive_r;
    assign delete_enemies    = del_r;
    assign cleared           = clr_r;
    assign landed            = lnd_r;

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Directed bench for enemy_formation_ctrl; frame_clk toggles every 4 Clk (8-Clk frames).
module tb_enemy_formation_ctrl;

`ifdef ENEMY_SPEEDUP_EN
    localparam int unsigned TB_FPS = 30;
`else
    localparam int unsigned TB_FPS = 2;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       start = 1'b0;
    logic [7:0] enemy_hit = 8'h00;
    logic       enemy_direction_X, enemy_direction_Y;
    logic [9:0] formation_x, formation_y;
    logic [7:0] alive;
    logic       delete_enemies, cleared, landed;

    int         n_chk = 0;
    int         n_pass = 0;
    bit         ok;
    int         nsteps, cyc, drops;

    enemy_formation_ctrl #(.FRAMES_PER_STEP(TB_FPS)) u_dut (
        .Clk               (Clk),
        .Reset_n           (Reset_n),
        .frame_clk         (frame_clk),
        .start             (start),
        .enemy_hit         (enemy_hit),
        .enemy_direction_X (enemy_direction_X),
        .enemy_direction_Y (enemy_direction_Y),
        .formation_x       (formation_x),
        .formation_y       (formation_y),
        .alive             (alive),
        .delete_enemies    (delete_enemies),
        .cleared           (cleared),
        .landed            (landed)
    );

`ifdef ENEMY_SPEEDUP_EN
    logic [7:0] hit2 = 8'h00;
    logic       dx2, dy2, del2, clr2, lnd2;
    logic [9:0] x2, y2, x2_0;
    logic [7:0] alive2;

    enemy_formation_ctrl #(.FRAMES_PER_STEP(30), .SPEEDUP_DEC(4)) u_fast (
        .Clk               (Clk),
        .Reset_n           (Reset_n),
        .frame_clk         (frame_clk),
        .start             (start),
        .enemy_hit         (hit2),
        .enemy_direction_X (dx2),
        .enemy_direction_Y (dy2),
        .formation_x       (x2),
        .formation_y       (y2),
        .alive             (alive2),
        .delete_enemies    (del2),
        .cleared           (clr2),
        .landed            (lnd2)
    );
`endif

    always #5 Clk = ~Clk;

    initial begin : frame_gen
        forever begin
            repeat (4) @(negedge Clk);
            frame_clk = ~frame_clk;
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_step(input int budget, output bit got_step);
        logic [9:0] x0;
        x0 = formation_x;
        got_step = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (formation_x != x0) begin
                got_step = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drop(input int budget, output bit got_drop);
        got_drop = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (enemy_direction_Y) begin
                got_drop = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin : stim
        tick();
        tick();
        chk("rst_x", formation_x, 10'd20);
        chk("rst_y", formation_y, 10'd40);
        chk("rst_dirx", enemy_direction_X, 1'b1);
        chk("rst_diry", enemy_direction_Y, 1'b0);
        chk("rst_alive", alive, 8'hFF);
        chk("rst_del", delete_enemies, 1'b1);
        chk("rst_cleared", cleared, 1'b0);
        chk("rst_landed", landed, 1'b0);
        Reset_n = 1'b1;
        repeat (3) tick();
        chk("idle_del", delete_enemies, 1'b1);
        pulse_start();
        chk("start_del", delete_enemies, 1'b0);

`ifdef ENEMY_SPEEDUP_EN
        enemy_hit = 8'h0F;
        hit2 = 8'h7F;
        tick();
        enemy_hit = 8'h00;
        hit2 = 8'h00;
        chk("spd_alive", alive, 8'hF0);
        chk("spd_alive2", alive2, 8'h80);
        wait_step(400, ok);
        chk("spd_first_step", ok, 1'b1);
        cyc = 0;
        wait_step(400, ok);
        cyc = 0;
        begin
            logic [9:0] xs;
            xs = formation_x;
            for (int i = 0; i < 400; i++) begin
                tick();
                cyc++;
                if (formation_x != xs) break;
            end
        end
        chk("spd_period_4dead_clk", cyc, 18 * 8);
        x2_0 = x2;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (x2 != x2_0) break;
        end
        x2_0 = x2;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cyc++;
            if (x2 != x2_0) break;
        end
        chk("spd_period_floor_clk", cyc, 6 * 8);
`else
        // 37 steps right from 20, then the bounce drop
        nsteps = 0;
        for (int k = 0; k < 37; k++) begin
            wait_step(40, ok);
            if (ok) nsteps++;
        end
        chk("march37_steps", nsteps, 37);
        chk("march37_x", formation_x, 10'd168);
        chk("march37_y", formation_y, 10'd40);
        chk("march37_dirx", enemy_direction_X, 1'b1);
        wait_drop(40, ok);
        chk("drop1_seen", ok, 1'b1);
        chk("drop1_x", formation_x, 10'd168);
        chk("drop1_y", formation_y, 10'd50);
        chk("drop1_dirx", enemy_direction_X, 1'b0);
        tick();
        chk("drop1_diry_pulse", enemy_direction_Y, 1'b0);

        // hit on column 3 in the same Clk as a left step
        wait_step(40, ok);
        chk("left_step_seen", ok, 1'b1);
        chk("left_step_x", formation_x, 10'd164);
        repeat (15) tick();
        chk("prehit_x", formation_x, 10'd164);
        enemy_hit = 8'h08;
        tick();
        enemy_hit = 8'h00;
        chk("samehit_alive", alive, 8'hF7);
        chk("samehit_x", formation_x, 10'd160);
        enemy_hit = 8'h08;
        tick();
        enemy_hit = 8'h00;
        chk("deadhit_alive", alive, 8'hF7);

        // clear the wave
        enemy_hit = 8'hFF;
        tick();
        enemy_hit = 8'h00;
        for (int i = 0; i < 4; i++) if (!cleared) tick();
        chk("clr_cleared", cleared, 1'b1);
        chk("clr_del", delete_enemies, 1'b1);
        chk("clr_alive", alive, 8'h00);
        repeat (20) tick();
        chk("clr_hold_x", formation_x, 10'd160);
        pulse_start();
        tick();
        chk("reidle_x", formation_x, 10'd20);
        chk("reidle_y", formation_y, 10'd40);
        chk("reidle_alive", alive, 8'hFF);
        chk("reidle_cleared", cleared, 1'b0);
        enemy_hit = 8'hFF;
        tick();
        enemy_hit = 8'h00;
        chk("idle_hit_ignored", alive, 8'hFF);

        // only column 0 alive: bounce at x=588 (588+54 > 640)
        pulse_start();
        enemy_hit = 8'hFE;
        tick();
        enemy_hit = 8'h00;
        chk("col0_alive", alive, 8'h01);
        wait_drop(3000, ok);
        chk("col0_drop_seen", ok, 1'b1);
        chk("col0_drop_x", formation_x, 10'd588);
        chk("col0_drop_y", formation_y, 10'd50);
        chk("col0_drop_dirx", enemy_direction_X, 1'b0);

        // full formation down to the bottom
        enemy_hit = 8'h01;
        tick();
        enemy_hit = 8'h00;
        for (int i = 0; i < 4; i++) if (!cleared) tick();
        pulse_start();
        tick();
        pulse_start();
        drops = 0;
        cyc = 0;
        while (!landed && cyc < 30000) begin
            tick();
            cyc++;
            if (enemy_direction_Y) drops++;
        end
        chk("land_landed", landed, 1'b1);
        chk("land_drops", drops, 31);
        chk("land_y", formation_y, 10'd350);
        chk("land_x", formation_x, 10'd168);
        chk("land_dirx", enemy_direction_X, 1'b0);
        chk("land_del", delete_enemies, 1'b1);
        repeat (40) tick();
        chk("land_hold_x", formation_x, 10'd168);
        chk("land_hold_y", formation_y, 10'd350);

        // asynchronous reset while in DROP
        pulse_start();
        tick();
        pulse_start();
        enemy_hit = 8'h20;
        tick();
        enemy_hit = 8'h00;
        chk("rd_alive", alive, 8'hDF);
        nsteps = 0;
        for (int k = 0; k < 37; k++) begin
            wait_step(40, ok);
            if (ok) nsteps++;
        end
        chk("rd_steps", nsteps, 37);
        chk("rd_x", formation_x, 10'd168);
        repeat (16) tick();
        chk("rd_indrop_y", formation_y, 10'd40);
        chk("rd_indrop_dirx", enemy_direction_X, 1'b1);
        Reset_n = 1'b0;
        #2;
        chk("rd_x_async", formation_x, 10'd20);
        chk("rd_y_async", formation_y, 10'd40);
        chk("rd_dirx_async", enemy_direction_X, 1'b1);
        chk("rd_diry_async", enemy_direction_Y, 1'b0);
        chk("rd_alive_async", alive, 8'hFF);
        chk("rd_del_async", delete_enemies, 1'b1);
        chk("rd_landed_async", landed, 1'b0);
        chk("rd_cleared_async", cleared, 1'b0);
        Reset_n = 1'b1;
`endif
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
